// File: rtl/dma_copier.sv
// Bus-initiator DMA engine: CPU-visible SRC/DST/LEN/CTRL registers and a
// four-state copier that moves LEN words over the granted device bus.
module dma_copier #(
    parameter int               ABITS = 32,
    parameter int               DBITS = 32,
    parameter logic [ABITS-1:0] RBASE = 32'hF000_0100,
    parameter int               WSTEP = 4
) (
    input  logic             clk_i,
    input  logic             init_i,
    input  logic             lock_i,
    input  logic [ABITS-1:0] abus_i,
    inout  wire logic [DBITS-1:0] rbus_io,
    input  logic             re_i,
    input  logic [DBITS-1:0] wbus_i,
    input  logic             we_i,
    output logic             breq_o,
    input  logic             bgnt_i,
    output logic [ABITS-1:0] mabus_o,
    input  logic [DBITS-1:0] mrbus_i,
    output logic [DBITS-1:0] mwbus_o,
    output logic             mre_o,
    output logic             mwe_o,
    output logic             intr_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD, S_WR} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] src_q, src_d, dst_q, dst_d;
    logic [DBITS-1:0] len_q, len_d, buf_q, buf_d;
    logic             done_q, done_d, ovr_q, ovr_d, ie_q, ie_d;

    logic             hit, rsel, wsel, ctrl_wr, busy, go, stop, fin;
    logic [1:0]       roff;
    logic [DBITS-1:0] rdata;

    assign hit     = (abus_i[ABITS-1:4] == RBASE[ABITS-1:4]) && (abus_i[1:0] == 2'b00);
    assign roff    = abus_i[3:2];
    assign rsel    = re_i & hit;
    assign wsel    = we_i & hit;
    assign ctrl_wr = wsel && (roff == 2'd3);
    assign busy    = (state_q != S_IDLE);
    assign stop    = ctrl_wr & wbus_i[9];
    assign go      = ctrl_wr & wbus_i[8] & ~wbus_i[9];

    always_comb begin
        rdata = '0;
        case (roff)
            2'd0: rdata = DBITS'(src_q);
            2'd1: rdata = DBITS'(dst_q);
            2'd2: rdata = len_q;
            default: begin
                rdata[4] = ie_q;
                rdata[2] = busy;
                rdata[1] = ovr_q;
                rdata[0] = done_q;
            end
        endcase
    end

    assign rbus_io = rsel ? rdata : {DBITS{1'bz}};

    // Strobes follow the grant combinationally so a dropped grant never sees a strobe.
    assign breq_o  = busy;
    assign mre_o   = (state_q == S_RD) && bgnt_i && lock_i;
    assign mwe_o   = (state_q == S_WR) && bgnt_i && lock_i;
    assign mabus_o = (state_q == S_WR) ? dst_q : src_q;
    assign mwbus_o = buf_q;
    assign intr_o  = done_q & ie_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        buf_d   = buf_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        fin     = 1'b0;

        if (wsel && !busy) begin
            case (roff)
                2'd0:    src_d = ABITS'(wbus_i);
                2'd1:    dst_d = ABITS'(wbus_i);
                2'd2:    len_d = wbus_i;
                default: ;
            endcase
        end
        if (ctrl_wr) begin
            ie_d = wbus_i[4];
            if (!wbus_i[0]) done_d = 1'b0;
            if (!wbus_i[1]) ovr_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: if (go) begin
                if (len_q != '0) state_d = S_REQ;
                else             fin     = 1'b1;
            end
            S_REQ: if (bgnt_i) state_d = S_RD;
            S_RD: if (bgnt_i) begin
                buf_d   = mrbus_i;
                state_d = S_WR;
            end
            S_WR: if (bgnt_i) begin
                src_d = src_q + ABITS'(WSTEP);
                dst_d = dst_q + ABITS'(WSTEP);
                len_d = len_q - DBITS'(1);
                if (len_q == DBITS'(1)) begin
                    state_d = S_IDLE;
                    fin     = 1'b1;
                end else begin
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busy && go)   ovr_d   = 1'b1;
        if (busy && stop) state_d = S_IDLE;
        // Completion is applied after the CTRL clear so a coincident clear loses.
        if (fin) begin
            done_d = 1'b1;
            if (done_q) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else if (lock_i) begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

endmodule
